psg_stereo_mixer: RTL
=====================

PSG_STEREO_MIXER -- requirements
Module: psg_stereo_mixer

Interface
REQ-001 SHALL have parameter EAR_LEVEL, default 192, the PCM weight added when ear=1.
REQ-002 SHALL have parameter MIC_LEVEL, default 32, the PCM weight added when mic=1.
REQ-003 clk  input  1  sole clock; all state on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clken  input  1  sample strobe, the same enable that drives the PSG.
REQ-006 channel_a, channel_b, channel_c  input  8 each  PSG channel levels, unsigned.
REQ-007 ear, mic  input  1 each  beeper/tape bits.
REQ-008 mode  input  2  00=ABC, 01=ACB, 10=mono, 11=PSG muted (beeper only).
REQ-009 left_pcm, right_pcm  output  10 each  mixed unsigned PCM, registered.
REQ-010 pcm_valid  output  1  one-cycle pulse when left_pcm/right_pcm update.
REQ-011 dac_l, dac_r  output  1 each  first-order sigma-delta bitstreams, registered.
REQ-012 overrun  output  1  sticky flag, set when a sample strobe is dropped.

Function
REQ-013 FSM states SHALL be IDLE, SUM_L, SUM_R and COMMIT; the FSM advances one state per clk, independent of clken.
REQ-014 In IDLE with clken=1, the block SHALL latch channel_a/b/c, ear, mic and mode into snapshot registers and enter SUM_L; otherwise it SHALL stay in IDLE.
REQ-015 SUM_L SHALL compute the left sum into an 11-bit accumulator and go to SUM_R; SUM_R SHALL compute the right sum and go to COMMIT; COMMIT SHALL update the outputs and return to IDLE.
REQ-016 Sums SHALL use only snapshot values; input changes after capture SHALL NOT affect the sample in flight.
REQ-017 The beeper term SHALL be bp = (ear ? EAR_LEVEL : 0) + (mic ? MIC_LEVEL : 0).
REQ-018 ABC: left = 2A + B + bp; right = 2C + B + bp.
REQ-019 ACB: left = 2A + C + bp; right = 2B + C + bp.
REQ-020 Mono: left = right = A + B + C + bp.
REQ-021 Muted: left = right = bp.
REQ-022 All sums SHALL be computed at at least 11 bits, and any result above 1023 SHALL saturate to 1023 in COMMIT.
REQ-023 Latency: with clken sampled high at edge N, left_pcm/right_pcm SHALL take the new values at edge N+3, and pcm_valid SHALL be high for exactly the cycle following edge N+3.
REQ-024 clken=1 while the state is not IDLE SHALL be ignored for capture and SHALL set overrun=1; overrun clears only on reset.
REQ-025 In COMMIT with clken=1, the strobe SHALL count as an overrun; the next capture is possible only from IDLE.
REQ-026 Each channel SHALL have a sigma-delta modulator updating every clk (not gated by clken): acc11 <= {1'b0, acc11[9:0]} + pcm; dac = acc11[10].
REQ-027 pcm=0 SHALL give dac constantly 0; pcm=P SHALL give exactly P ones in every 1024 consecutive clk cycles once steady.

Reset
REQ-028 When rst_n=0, regardless of clk, the block SHALL immediately force state=IDLE, all snapshots=0, left_pcm=right_pcm=0, pcm_valid=0, sigma-delta accumulators=0, dac_l=dac_r=0 and overrun=0.
REQ-029 Reset asserted mid-sample SHALL discard that sample; after release, pcm_valid SHALL NOT pulse until a fresh clken capture has run the full sequence.
REQ-030 The first clken accepted after rst_n release SHALL be captured normally.

Verification
REQ-031 Mode=00, A=100, B=50, C=10, ear=mic=0, one clken -> left_pcm=250, right_pcm=70, with pcm_valid pulsed 4 edges after the strobe.
REQ-032 Mode=10, A=B=C=255, ear=mic=1, defaults -> left_pcm=right_pcm=989; then mode=11 with ear=1, mic=0 -> both=192.
REQ-033 EAR_LEVEL=MIC_LEVEL=255, mode=00, A=B=C=255, ear=mic=1 -> both outputs saturate at 1023.
REQ-034 Inputs changed the cycle after capture -> outputs reflect the captured values; clken pulsed at edges N and N+2 -> second strobe ignored, overrun=1 and stays 1.
REQ-035 left_pcm=512 held steady -> dac_l has exactly 512 ones in 1024 cycles; left_pcm=0 -> dac_l=0 throughout.
REQ-036 rst_n pulsed low during SUM_R -> all outputs are 0 immediately, no pcm_valid follows, and the next clken produces a correct sample.

Source files
------------

// File: rtl/psg_stereo_mixer.sv
// ============================================================================
//  Module   : psg_stereo_mixer
//  Purpose  : Mixes three PSG channels plus beeper bits into stereo 10-bit PCM
//             and drives a first-order sigma-delta bitstream per channel.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psg_stereo_mixer #(
    parameter int EAR_LEVEL = 192,
    parameter int MIC_LEVEL = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clken,
    input  logic [7:0] channel_a,
    input  logic [7:0] channel_b,
    input  logic [7:0] channel_c,
    input  logic       ear,
    input  logic       mic,
    input  logic [1:0] mode,
    output logic [9:0] left_pcm,
    output logic [9:0] right_pcm,
    output logic       pcm_valid,
    output logic       dac_l,
    output logic       dac_r,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUM_L  = 2'd1,
        SUM_R  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [10:0] c_ear_level = 11'(EAR_LEVEL);
    localparam logic [10:0] c_mic_level = 11'(MIC_LEVEL);

    state_t      r_state;
    logic [7:0]  r_a, r_b, r_c;
    logic        r_ear, r_mic;
    logic [1:0]  r_mode;
    logic [10:0] r_acc_l, r_acc_r;
    logic [10:0] r_sd_l, r_sd_r;

    logic [10:0] w_a, w_b, w_c, w_bp, w_sum_l, w_sum_r;

    assign w_a  = {3'b000, r_a};
    assign w_b  = {3'b000, r_b};
    assign w_c  = {3'b000, r_c};
    assign w_bp = (r_ear ? c_ear_level : 11'd0) + (r_mic ? c_mic_level : 11'd0);

    always_comb begin
        w_sum_l = w_bp;
        w_sum_r = w_bp;
        case (r_mode)
            2'b00: begin
                w_sum_l = (w_a << 1) + w_b + w_bp;
                w_sum_r = (w_c << 1) + w_b + w_bp;
            end
            2'b01: begin
                w_sum_l = (w_a << 1) + w_c + w_bp;
                w_sum_r = (w_b << 1) + w_c + w_bp;
            end
            2'b10: begin
                w_sum_l = w_a + w_b + w_c + w_bp;
                w_sum_r = w_a + w_b + w_c + w_bp;
            end
            default: begin
                w_sum_l = w_bp;
                w_sum_r = w_bp;
            end
        endcase
    end

    // Strobes arriving outside IDLE (COMMIT included) are dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_ear     <= 1'b0;
            r_mic     <= 1'b0;
            r_mode    <= '0;
            r_acc_l   <= '0;
            r_acc_r   <= '0;
            left_pcm  <= '0;
            right_pcm <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (clken && (r_state != IDLE))
                overrun <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (clken) begin
                        r_a     <= channel_a;
                        r_b     <= channel_b;
                        r_c     <= channel_c;
                        r_ear   <= ear;
                        r_mic   <= mic;
                        r_mode  <= mode;
                        r_state <= SUM_L;
                    end
                end
                SUM_L: begin
                    r_acc_l <= w_sum_l;
                    r_state <= SUM_R;
                end
                SUM_R: begin
                    r_acc_r <= w_sum_r;
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    left_pcm  <= r_acc_l[10] ? 10'h3FF : r_acc_l[9:0];
                    right_pcm <= r_acc_r[10] ? 10'h3FF : r_acc_r[9:0];
                    pcm_valid <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The carry out of the 10-bit phase is the bitstream; it fires P times per 1024 clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sd_l <= '0;
            r_sd_r <= '0;
        end else begin
            r_sd_l <= {1'b0, r_sd_l[9:0]} + {1'b0, left_pcm};
            r_sd_r <= {1'b0, r_sd_r[9:0]} + {1'b0, right_pcm};
        end
    end

    assign dac_l = r_sd_l[10];
    assign dac_r = r_sd_r[10];

endmodule

`default_nettype wire
